// File: rtl/z16_program_loader.sv
// Z16 imem loader: byte stream -> 16-bit LE words at BASE_ADDR+2k; holds CPU in reset until loaded (Z16_LOADER_CHECKSUM_EN adds a trailing sum byte).
// Latency: write strobe 1 cycle after the HI byte is accepted; o_done/o_cpu_rst change 1 cycle after DONE is entered.
// Backpressure: o_byte_ready high while loading, low in DONE/ERR; timeout ERR if the source idles too long mid-image.
module z16_program_loader #(
   parameter logic [15:0] BASE_ADDR      = 16'h0000,
   parameter int unsigned MAX_WORDS      = 256,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_byte_valid,
   input  logic [7:0]  i_byte_data,
   output logic        o_byte_ready,
   output logic        o_imem_wen,
   output logic [15:0] o_imem_addr,
   output logic [15:0] o_imem_wdata,
   output logic        o_cpu_rst,
   output logic        o_done,
   output logic        o_error
);

   typedef enum logic [2:0] {
      S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CSUM, S_DONE, S_ERR
   } state_t;

   localparam logic [31:0] TMO_LIM = TIMEOUT_CYCLES;
   localparam logic [31:0] MAX_W   = MAX_WORDS;

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  lo_q, lo_d;
   logic [31:0] tmo_q, tmo_d;
   logic        wen_q, wen_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        done_q, cpu_rst_q;
   logic        accept, timed;
`ifdef Z16_LOADER_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif

   assign o_byte_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                         (state_q == S_DATA_LO) || (state_q == S_DATA_HI) ||
                         (state_q == S_CSUM);
   assign accept       = i_byte_valid && o_byte_ready;
   // LEN_LO is deliberately untimed: the loader may wait forever for an image to start.
   assign timed        = o_byte_ready && (state_q != S_LEN_LO);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      lo_d    = lo_q;
      tmo_d   = tmo_q;
      wen_d   = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef Z16_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      if (accept) begin
         tmo_d = '0;
`ifdef Z16_LOADER_CHECKSUM_EN
         csum_d = csum_q + i_byte_data;
`endif
         case (state_q)
            S_LEN_LO: begin
               len_d[7:0] = i_byte_data;
               state_d    = S_LEN_HI;
            end
            S_LEN_HI: begin
               len_d[15:8] = i_byte_data;
               if (32'({i_byte_data, len_q[7:0]}) > MAX_W)
                  state_d = S_ERR;
               else if ({i_byte_data, len_q[7:0]} == 16'd0)
`ifdef Z16_LOADER_CHECKSUM_EN
                  state_d = S_CSUM;
`else
                  state_d = S_DONE;
`endif
               else
                  state_d = S_DATA_LO;
            end
            S_DATA_LO: begin
               lo_d    = i_byte_data;
               state_d = S_DATA_HI;
            end
            S_DATA_HI: begin
               wen_d   = 1'b1;
               addr_d  = BASE_ADDR + {cnt_q[14:0], 1'b0};
               wdata_d = {i_byte_data, lo_q};
               cnt_d   = cnt_q + 16'd1;
               if (cnt_q + 16'd1 == len_q)
`ifdef Z16_LOADER_CHECKSUM_EN
                  state_d = S_CSUM;
`else
                  state_d = S_DONE;
`endif
               else
                  state_d = S_DATA_LO;
            end
`ifdef Z16_LOADER_CHECKSUM_EN
            S_CSUM: state_d = (i_byte_data == csum_q) ? S_DONE : S_ERR;
`endif
            default: ;
         endcase
      end else if (timed) begin
         if ((TMO_LIM != 32'd0) && (tmo_q >= TMO_LIM - 32'd1))
            state_d = S_ERR;
         else
            tmo_d = tmo_q + 32'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_LEN_LO;
         len_q     <= '0;
         cnt_q     <= '0;
         lo_q      <= '0;
         tmo_q     <= '0;
         wen_q     <= 1'b0;
         addr_q    <= BASE_ADDR;
         wdata_q   <= '0;
         done_q    <= 1'b0;
         cpu_rst_q <= 1'b1;
`ifdef Z16_LOADER_CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         lo_q      <= lo_d;
         tmo_q     <= tmo_d;
         wen_q     <= wen_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         done_q    <= (state_q == S_DONE);
         cpu_rst_q <= (state_q != S_DONE);
`ifdef Z16_LOADER_CHECKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   assign o_imem_wen   = wen_q;
   assign o_imem_addr  = addr_q;
   assign o_imem_wdata = wdata_q;
   assign o_done       = done_q;
   assign o_cpu_rst    = cpu_rst_q;
   assign o_error      = (state_q == S_ERR);

endmodule

// File: tb/tb_z16_program_loader.sv
// Directed bench for z16_program_loader: table-driven basic load plus hand sequences for length, timeout, reset and wrap.
module tb_z16_program_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, vld;
   logic [7:0]  dat;
   logic        a_rdy, a_wen, a_cpu_rst, a_done, a_err;
   logic [15:0] a_addr, a_wd;
   logic        b_rdy, b_wen, b_cpu_rst, b_done, b_err;
   logic [15:0] b_addr, b_wd;

   z16_program_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(256), .TIMEOUT_CYCLES(8)) u_a (
      .i_clk(clk), .i_rst(rst), .i_byte_valid(vld), .i_byte_data(dat),
      .o_byte_ready(a_rdy), .o_imem_wen(a_wen), .o_imem_addr(a_addr), .o_imem_wdata(a_wd),
      .o_cpu_rst(a_cpu_rst), .o_done(a_done), .o_error(a_err));

   z16_program_loader #(.BASE_ADDR(16'hFFFE), .MAX_WORDS(256), .TIMEOUT_CYCLES(0)) u_b (
      .i_clk(clk), .i_rst(rst), .i_byte_valid(vld), .i_byte_data(dat),
      .o_byte_ready(b_rdy), .o_imem_wen(b_wen), .o_imem_addr(b_addr), .o_imem_wdata(b_wd),
      .o_cpu_rst(b_cpu_rst), .o_done(b_done), .o_error(b_err));

   typedef struct {
      logic [15:0] addr;
      logic [15:0] wd;
      int          cyc;
   } wr_t;

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        rdy, wen;
      logic [15:0] addr, wd;
      logic        done, cpu_rst, err;
   } vec_t;

   wr_t q_a[$];
   wr_t q_b[$];
   int  cyc = 0;
   int  checks = 0;
   int  failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (a_wen) q_a.push_back('{a_addr, a_wd, cyc});
      if (b_wen) q_b.push_back('{b_addr, b_wd, cyc});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      vld = 1'b0;
      dat = 8'h00;
      tick();
      rst = 1'b0;
      q_a.delete();
      q_b.delete();
   endtask

   task automatic send(input logic [7:0] b);
      vld = 1'b1;
      dat = b;
      tick();
      vld = 1'b0;
   endtask

   task automatic idle(input int n);
      vld = 1'b0;
      repeat (n) tick();
   endtask

   // Trailing checksum byte only exists when the feature is built in.
   task automatic csum(input logic [7:0] s);
`ifdef Z16_LOADER_CHECKSUM_EN
      send(s);
`else
      if (s == 8'h00) vld = 1'b0;
`endif
   endtask

   function automatic vec_t mk(logic v, logic [7:0] d, logic r, logic w, logic [15:0] a,
                               logic [15:0] wd, logic dn, logic cr, logic er);
      vec_t t;
      t.v = v; t.d = d; t.rdy = r; t.wen = w; t.addr = a; t.wd = wd;
      t.done = dn; t.cpu_rst = cr; t.err = er;
      return t;
   endfunction

   vec_t tbl[9];
   logic [7:0] strm[$];

   initial begin
      rst = 1'b0;
      vld = 1'b0;
      dat = 8'h00;

      // Basic image 02 00 11 22 33 44: one row per cycle, outputs observed before that cycle's edge.
      tbl[0] = mk(1, 8'h02, 1, 0, 16'h0000, 16'h0000, 0, 1, 0);
      tbl[1] = mk(1, 8'h00, 1, 0, 16'h0000, 16'h0000, 0, 1, 0);
      tbl[2] = mk(1, 8'h11, 1, 0, 16'h0000, 16'h0000, 0, 1, 0);
      tbl[3] = mk(1, 8'h22, 1, 0, 16'h0000, 16'h0000, 0, 1, 0);
      tbl[4] = mk(1, 8'h33, 1, 1, 16'h0000, 16'h2211, 0, 1, 0);
      tbl[5] = mk(1, 8'h44, 1, 0, 16'h0000, 16'h2211, 0, 1, 0);
`ifdef Z16_LOADER_CHECKSUM_EN
      tbl[6] = mk(1, 8'hAC, 1, 1, 16'h0002, 16'h4433, 0, 1, 0);
      tbl[7] = mk(1, 8'h55, 0, 0, 16'h0002, 16'h4433, 0, 1, 0);
      tbl[8] = mk(0, 8'h00, 0, 0, 16'h0002, 16'h4433, 1, 0, 0);
`else
      tbl[6] = mk(0, 8'h00, 0, 1, 16'h0002, 16'h4433, 0, 1, 0);
      tbl[7] = mk(1, 8'h55, 0, 0, 16'h0002, 16'h4433, 1, 0, 0);
      tbl[8] = mk(0, 8'h00, 0, 0, 16'h0002, 16'h4433, 1, 0, 0);
`endif

      do_reset();
      for (int i = 0; i < 9; i++) begin
         vld = tbl[i].v;
         dat = tbl[i].d;
         chk($sformatf("t1_r%0d_rdy", i),  32'(a_rdy),     32'(tbl[i].rdy));
         chk($sformatf("t1_r%0d_wen", i),  32'(a_wen),     32'(tbl[i].wen));
         chk($sformatf("t1_r%0d_addr", i), 32'(a_addr),    32'(tbl[i].addr));
         chk($sformatf("t1_r%0d_wd", i),   32'(a_wd),      32'(tbl[i].wd));
         chk($sformatf("t1_r%0d_done", i), 32'(a_done),    32'(tbl[i].done));
         chk($sformatf("t1_r%0d_crst", i), 32'(a_cpu_rst), 32'(tbl[i].cpu_rst));
         chk($sformatf("t1_r%0d_err", i),  32'(a_err),     32'(tbl[i].err));
         tick();
      end
      vld = 1'b0;
      chk("t1_nwrites", 32'(q_a.size()), 32'd2);

`ifdef Z16_LOADER_CHECKSUM_EN
      // Bad checksum: words still written, CPU kept in reset.
      do_reset();
      send(8'h02); send(8'h00); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      send(8'hAD);
      idle(1);
      chk("t2_err",     32'(a_err),     32'd1);
      chk("t2_cpu_rst", 32'(a_cpu_rst), 32'd1);
      chk("t2_done",    32'(a_done),    32'd0);
      chk("t2_nwrites", 32'(q_a.size()), 32'd2);
`endif

      // Length over MAX_WORDS, then exactly MAX_WORDS.
      do_reset();
      send(8'h01); send(8'h01);
      chk("t3_err",     32'(a_err),     32'd1);
      chk("t3_rdy",     32'(a_rdy),     32'd0);
      chk("t3_cpu_rst", 32'(a_cpu_rst), 32'd1);
      send(8'hAA); send(8'hBB); idle(2);
      chk("t3_nwrites", 32'(q_a.size()), 32'd0);
      chk("t3_err_hold", 32'(a_err), 32'd1);
      do_reset();
      send(8'h00); send(8'h01);
      chk("t3_max_err", 32'(a_err), 32'd0);
      chk("t3_max_rdy", 32'(a_rdy), 32'd1);

      // Timeout: LEN_LO never times out; 7 idle cycles survive, 8 do not.
      do_reset();
      idle(20);
      chk("t4_lenlo_err", 32'(a_err), 32'd0);
      chk("t4_lenlo_rdy", 32'(a_rdy), 32'd1);
      send(8'h05);
      idle(7);
      chk("t4_stall7_err", 32'(a_err), 32'd0);
      send(8'h00);
      chk("t4_accept_err", 32'(a_err), 32'd0);
      chk("t4_accept_rdy", 32'(a_rdy), 32'd1);
      idle(7);
      chk("t4_pre_err", 32'(a_err), 32'd0);
      idle(1);
      chk("t4_tmo_err", 32'(a_err), 32'd1);
      chk("t4_tmo_rdy", 32'(a_rdy), 32'd0);
      chk("t4_nodis_err", 32'(b_err), 32'd0);

      // Reset mid-image restarts at BASE_ADDR.
      do_reset();
      send(8'h03); send(8'h00); send(8'h11); send(8'h22);
      idle(1);
      chk("t5_w0_n",    32'(q_a.size()), 32'd1);
      chk("t5_w0_addr", 32'(q_a[0].addr), 32'h0000);
      chk("t5_w0_wd",   32'(q_a[0].wd),   32'h2211);
      send(8'h33);
      do_reset();
      chk("t5_rst_wd",   32'(a_wd),      32'h0000);
      chk("t5_rst_addr", 32'(a_addr),    32'h0000);
      chk("t5_rst_rdy",  32'(a_rdy),     32'd1);
      chk("t5_rst_crst", 32'(a_cpu_rst), 32'd1);
      send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
      csum(8'h66);
      idle(1);
      chk("t5_r_n",    32'(q_a.size()), 32'd1);
      chk("t5_r_addr", 32'(q_a[0].addr), 32'h0000);
      chk("t5_r_wd",   32'(q_a[0].wd),   32'hBBAA);
      chk("t5_r_done", 32'(a_done), 32'd1);
      chk("t5_r_crst", 32'(a_cpu_rst), 32'd0);

      // Address wrap at FFFE with a long stall (timeout disabled on that instance).
      do_reset();
      send(8'h02); send(8'h00); send(8'h11); send(8'h22);
      idle(50);
      send(8'h33); send(8'h44);
      csum(8'hAC);
      idle(1);
      chk("t5b_n",     32'(q_b.size()), 32'd2);
      chk("t5b_addr0", 32'(q_b[0].addr), 32'hFFFE);
      chk("t5b_wd0",   32'(q_b[0].wd),   32'h2211);
      chk("t5b_addr1", 32'(q_b[1].addr), 32'h0000);
      chk("t5b_wd1",   32'(q_b[1].wd),   32'h4433);
      chk("t5b_done",  32'(b_done), 32'd1);
      chk("t5b_err",   32'(b_err),  32'd0);
      chk("t5b_a_tmo", 32'(a_err),  32'd1);

      // Back-to-back stream, N=4: a strobe every 2 cycles, none lost.
      do_reset();
      strm = '{8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
`ifdef Z16_LOADER_CHECKSUM_EN
      strm.push_back(8'h28);
`endif
      for (int i = 0; i < strm.size(); i++) begin
         vld = 1'b1;
         dat = strm[i];
         chk($sformatf("t6_rdy%0d", i), 32'(a_rdy), 32'd1);
         tick();
      end
      idle(1);
      chk("t6_n", 32'(q_a.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < q_a.size()) begin
            chk($sformatf("t6_addr%0d", i), 32'(q_a[i].addr), 32'(2 * i));
            chk($sformatf("t6_wd%0d", i), 32'(q_a[i].wd), 32'({8'(2 * i + 2), 8'(2 * i + 1)}));
            if (i > 0)
               chk($sformatf("t6_gap%0d", i), 32'(q_a[i].cyc - q_a[i-1].cyc), 32'd2);
         end
      end
      chk("t6_done", 32'(a_done), 32'd1);
      chk("t6_err",  32'(a_err),  32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

endmodule
